vector_exec_unit: RTL and testbench
===================================

VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 The block SHALL have one parameter: bits, default 16, element width in bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first).
REQ-003 CLK  input  1  rising-edge clock shared with the vector register bank.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 START  input  1  request a vector operation; sampled only in IDLE.
REQ-006 OP  input  3  operation code; captured with START.
REQ-007 VDST  input  1  destination vector register index; captured with START.
REQ-008 VA  input  [9:0][bits-1:0]  source vector A, driven from bank read port VD1; captured with START.
REQ-009 VB  input  [9:0][bits-1:0]  source vector B, driven from bank read port VD2; captured with START.
REQ-010 WE3  output  1  bank write enable.
REQ-011 V3  output  1  bank write index.
REQ-012 WD3  output  [9:0][bits-1:0]  bank write data (result vector).
REQ-013 BUSY  output  1  operation in progress.
REQ-014 DONE  output  1  one-cycle completion pulse.

Function
REQ-015 The block SHALL implement the FSM states IDLE, EXEC and WRITE.
REQ-016 On a rising edge in IDLE with START=1, the block SHALL capture VA, VB, OP and VDST into internal registers, clear element index idx to 0, and enter EXEC.
REQ-017 In EXEC, each edge SHALL compute res[idx] = f(OP, A[idx], B[idx]); if idx=9 the state SHALL go to WRITE, else idx SHALL increment by 1.
REQ-018 EXEC SHALL last exactly 10 cycles, one element per cycle, in order from element 0 to element 9.
REQ-019 In WRITE, WE3=1, DONE=1, V3=captured VDST and WD3=res SHALL all hold for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-020 Latency: WE3 SHALL rise 10 edges after the edge that samples START; the whole operation SHALL take 11 cycles from that edge to return to IDLE.
REQ-021 BUSY SHALL be 1 in EXEC and WRITE and 0 in IDLE; WE3 and DONE SHALL be 0 outside WRITE.
REQ-022 START SHALL be ignored in EXEC and WRITE, with no queuing; the next operation can be accepted no earlier than the first IDLE cycle.
REQ-023 Changes on VA, VB, OP or VDST after capture SHALL NOT affect the operation in flight.
REQ-024 OP encodings, all modulo 2^bits and unsigned unless stated:
  - 000 ADD: A+B, wraps
  - 001 SUB: A-B, wraps
  - 010 MUL: low bits of A*B
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 ADDS: unsigned saturating add, clamps to 2^bits-1
  - 111 MOV: A
REQ-025 WD3 SHALL hold the last completed result vector in IDLE; V3 SHALL hold the last captured VDST.
REQ-026 Res elements not yet computed in the current operation SHALL retain their previous values.
REQ-027 VDST equal to a source register index is legal, because sources are captured at START.

Reset
REQ-028 On an edge with RST=1, the block SHALL reset as follows, and RST SHALL take priority over START:
  - state set to IDLE, idx set to 0, all res elements and captured operands set to 0
  - WE3, DONE, BUSY and V3 set to 0
REQ-029 Reset during EXEC or WRITE SHALL abort the operation; no WE3 pulse SHALL be produced for it.

Verification
REQ-030 Reset, then idle 5 cycles -> WE3=DONE=BUSY=0, WD3 all zero, V3=0.
REQ-031 VA[i]=i, VB[i]=100, OP=000, VDST=1, START one cycle -> BUSY for 11 cycles; WE3 and DONE high exactly at cycle 11; V3=1; WD3[i]=100+i.
REQ-032 VA[i]=16'hFFF0, VB[i]=16'h0020, run OP=000, then 110, then 001 -> results 16'h0010, 16'hFFFF, 16'hFFD0.
REQ-033 OP=010 with VA[i]=16'h0100, VB[i]=16'h0101; START re-asserted on every cycle during the operation and VA changed mid-operation -> exactly one WE3 pulse; WD3[i]=16'h0100.
REQ-034 START, then RST=1 at the 5th EXEC cycle -> no WE3 pulse, BUSY=0 next cycle, WD3 all zero.
REQ-035 START asserted in the first IDLE cycle after DONE -> second operation accepted; WE3 pulses for the two operations are 12 cycles apart.

Source files
------------

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: applies one element-wise operation to two 10-element
// vectors, one element per cycle, and writes the result vector back to the
// vector register bank in a single write cycle.
//
// Ports:
//   CLK    rising-edge clock shared with the vector register bank
//   RST    synchronous active-high reset (takes priority over START)
//   START  operation request, only sampled in IDLE
//   OP     operation code, captured with START
//   VDST   destination register index, captured with START
//   VA/VB  source vectors (bank read ports VD1/VD2), captured with START
//   WE3    bank write enable, high for the single WRITE cycle
//   V3     bank write index (last captured VDST)
//   WD3    bank write data (result vector, holds last result in IDLE)
//   BUSY   high while in EXEC or WRITE
//   DONE   one-cycle completion pulse, coincident with WE3
module vector_exec_unit #(
    parameter int unsigned bits = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [2:0]                OP,
    input  logic                      VDST,
    input  logic [9:0][bits-1:0]      VA,
    input  logic [9:0][bits-1:0]      VB,
    output logic                      WE3,
    output logic                      V3,
    output logic [9:0][bits-1:0]      WD3,
    output logic                      BUSY,
    output logic                      DONE
);

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = 9;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ADDS = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [2:0]             op_q, op_d;
    logic                   vdst_q, vdst_d;
    logic [9:0][bits-1:0]   a_q, a_d;
    logic [9:0][bits-1:0]   b_q, b_d;
    logic [9:0][bits-1:0]   res_q, res_d;
    logic                   we3_q, we3_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    // Single-element ALU; all arithmetic modulo 2^bits, unsigned.
    function automatic logic [bits-1:0] alu(
        input logic [2:0]      op,
        input logic [bits-1:0] a,
        input logic [bits-1:0] b
    );
        logic [bits:0]   sum;
        logic [bits-1:0] r;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  r = sum[bits-1:0];
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADDS: r = sum[bits] ? {bits{1'b1}} : sum[bits-1:0];
            OP_MOV:  r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        vdst_d  = vdst_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = VA;
                    b_d     = VB;
                    op_d    = OP;
                    vdst_d  = VDST;
                    idx_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Elements beyond idx keep their previous result.
                res_d[idx_q] = alu(op_q, a_q[idx_q], b_q[idx_q]);
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    idx_d   = '0;
                    state_d = WRITE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they follow the state being entered.
        we3_d  = (state_d == WRITE);
        done_d = (state_d == WRITE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            vdst_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            we3_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            vdst_q  <= vdst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            we3_q   <= we3_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign WE3  = we3_q;
    assign DONE = done_q;
    assign BUSY = busy_q;
    assign V3   = vdst_q;
    assign WD3  = res_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit (bits = 16).
module tb_vector_exec_unit;

    typedef logic [9:0][15:0] vec_t;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [2:0]  OP;
    logic        VDST;
    vec_t        VA;
    vec_t        VB;
    logic        WE3;
    logic        V3;
    vec_t        WD3;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;

    vector_exec_unit #(.bits(16)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .VDST  (VDST),
        .VA    (VA),
        .VB    (VB),
        .WE3   (WE3),
        .V3    (V3),
        .WD3   (WD3),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t fill(input logic [15:0] v);
        vec_t r;
        for (int i = 0; i < 10; i++) r[i] = v;
        return r;
    endfunction

    // Runs one operation over 12 observed cycles (cycle k follows edge k-1,
    // edge 0 samples START) and reports what the outputs did.
    task automatic run_op(input logic [2:0] op, input logic vd, input vec_t va, input vec_t vb,
                          input bit hammer, output int busy_n, output int we_n,
                          output int we_at, output int done_at, output vec_t wd_at,
                          output logic v3_at);
        OP = op; VDST = vd; VA = va; VB = vb; START = 1'b1;
        busy_n = 0; we_n = 0; we_at = -1; done_at = -1; wd_at = '0; v3_at = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (BUSY) busy_n++;
            if (WE3) begin
                we_n++;
                we_at = k;
                wd_at = WD3;
                v3_at = V3;
            end
            if (DONE) done_at = k;
            if (hammer) begin
                START = (k <= 11);
                VA    = fill(16'h0003);
                OP    = 3'b000;
                VDST  = ~vd;
            end else begin
                START = 1'b0;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic vd,
                         input vec_t va, input vec_t vb, input vec_t exp, input bit hammer);
        int   busy_n, we_n, we_at, done_at;
        vec_t wd_at;
        logic v3_at;
        run_op(op, vd, va, vb, hammer, busy_n, we_n, we_at, done_at, wd_at, v3_at);
        check({tag, " busy_cycles"}, 160'(busy_n), 160'(11));
        check({tag, " we3_count"},   160'(we_n),   160'(1));
        check({tag, " we3_cycle"},   160'(we_at),  160'(11));
        check({tag, " done_cycle"},  160'(done_at), 160'(11));
        check({tag, " wd3"},         wd_at,        exp);
        check({tag, " v3"},          160'(v3_at),  160'(vd));
        check({tag, " wd3_hold"},    WD3,          exp);
    endtask

    initial begin
        vec_t va, vb, ex;
        int   we_cnt, we1, we2;
        RST = 1'b1; START = 1'b1; OP = 3'b000; VDST = 1'b1;
        VA = fill(16'h1234); VB = fill(16'h1111);
        tick();
        tick();
        check("reset_prio_busy", 160'(BUSY), 160'(0));
        RST = 1'b0; START = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_we3",  160'(WE3),  160'(0));
        check("idle_done", 160'(DONE), 160'(0));
        check("idle_busy", 160'(BUSY), 160'(0));
        check("idle_wd3",  WD3,        160'(0));
        check("idle_v3",   160'(V3),   160'(0));

        // Ramp add: WD3[i] = 100 + i
        for (int i = 0; i < 10; i++) begin
            va[i] = 16'(i);
            vb[i] = 16'd100;
            ex[i] = 16'(100 + i);
        end
        do_op("add_ramp", 3'b000, 1'b1, va, vb, ex, 1'b0);

        // Wrap / saturate / subtract corner values
        do_op("add_wrap", 3'b000, 1'b0, fill(16'hFFF0), fill(16'h0020), fill(16'h0010), 1'b0);
        do_op("adds_sat", 3'b110, 1'b1, fill(16'hFFF0), fill(16'h0020), fill(16'hFFFF), 1'b0);
        do_op("sub_wrap", 3'b001, 1'b0, fill(16'hFFF0), fill(16'h0020), fill(16'hFFD0), 1'b0);
        do_op("adds_nosat", 3'b110, 1'b1, fill(16'h1000), fill(16'h0234), fill(16'h1234), 1'b0);

        // Logic ops and move
        do_op("and", 3'b011, 1'b0, fill(16'hF0F0), fill(16'hFF00), fill(16'hF000), 1'b0);
        do_op("or",  3'b100, 1'b1, fill(16'hF0F0), fill(16'hFF00), fill(16'hFFF0), 1'b0);
        do_op("xor", 3'b101, 1'b0, fill(16'hF0F0), fill(16'hFF00), fill(16'h0FF0), 1'b0);
        do_op("mov", 3'b111, 1'b1, fill(16'hF0F0), fill(16'hFF00), fill(16'hF0F0), 1'b0);

        // Multiply with START hammered and operands disturbed in flight
        do_op("mul_hammer", 3'b010, 1'b1, fill(16'h0100), fill(16'h0101), fill(16'h0100), 1'b1);

        // Reset after the 5th EXEC cycle aborts the operation
        OP = 3'b000; VDST = 1'b1; VA = fill(16'h0001); VB = fill(16'h0001); START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        check("abort_busy_pre", 160'(BUSY), 160'(1));
        RST = 1'b1;
        tick();
        check("abort_busy", 160'(BUSY), 160'(0));
        check("abort_wd3",  WD3,        160'(0));
        check("abort_v3",   160'(V3),   160'(0));
        RST = 1'b0;
        we_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (WE3) we_cnt++;
        end
        check("abort_no_we3", 160'(we_cnt), 160'(0));

        // Back-to-back: second START in first IDLE cycle after DONE
        OP = 3'b000; VDST = 1'b0; VA = fill(16'h0005); VB = fill(16'h0007); START = 1'b1;
        we_cnt = 0; we1 = -1; we2 = -1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (WE3) begin
                we_cnt++;
                if (we1 < 0) we1 = k;
                else we2 = k;
                if (k == 11) check("b2b_first_wd3", WD3, fill(16'h000C));
            end
            START = (k == 12);
            if (k == 12) begin
                OP = 3'b101; VDST = 1'b1; VA = fill(16'h00FF); VB = fill(16'h0F0F);
            end
        end
        check("b2b_we3_count", 160'(we_cnt),    160'(2));
        check("b2b_first_at",  160'(we1),       160'(11));
        check("b2b_spacing",   160'(we2 - we1), 160'(12));
        check("b2b_second_wd3", WD3,            fill(16'h0FF0));
        check("b2b_second_v3",  160'(V3),       160'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
